// File: rtl/kyber_pkg.sv
// Shared Kyber constants: modulus, coefficient width, polynomial RAM geometry
// and the lane map used by the matrix generator RAM layout.
package kyber_pkg;

  localparam int unsigned KYBER_Q    = 3329;
  localparam int unsigned COEFF_W    = 12;
  localparam int unsigned POLY_WORDS = 32;
  localparam int unsigned LANES      = 8;

  // Even lane of the coefficient pair selected on pass q (q = 0..3).
  localparam logic [3:0][2:0] LANE_EVEN = {3'd6, 3'd2, 3'd4, 3'd0};

  typedef struct packed {
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
  } byte_triple_t;

endpackage

// File: rtl/byte_pack12.sv
// ByteEncode12 packing of one coefficient pair into three bytes, plus a
// range flag for coefficients at or above the Kyber modulus. Purely combinational.
module byte_pack12
  import kyber_pkg::*;
(
  input  logic [COEFF_W-1:0] c0_i,
  input  logic [COEFF_W-1:0] c1_i,
  output byte_triple_t       triple_c,
  output logic               out_of_range_c
);

  always_comb begin
    triple_c.b0    = c0_i[7:0];
    triple_c.b1    = {c1_i[3:0], c0_i[11:8]};
    triple_c.b2    = c1_i[11:4];
    out_of_range_c = (c0_i >= COEFF_W'(KYBER_Q)) || (c1_i >= COEFF_W'(KYBER_Q));
  end

endmodule

// File: rtl/poly_byte_encoder.sv
// Streams one 256-coefficient polynomial from the lane-interleaved polynomial
// RAM as the 384-byte ByteEncode12 sequence over a valid/ready byte port.
module poly_byte_encoder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned COEFF_W = kyber_pkg::COEFF_W,
  parameter int unsigned WORDS   = kyber_pkg::POLY_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    ram_r_start_offset,
  output logic                 busy,
  output logic                 done,
  output logic                 ren,
  output logic [ADDR_W-1:0]    raddr,
  input  logic [8*COEFF_W-1:0] rdata,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 range_err
);
  import kyber_pkg::*;

  localparam int unsigned K_W = $clog2(WORDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [1:0]        q_q, q_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] off_q, off_d;
  byte_triple_t      hold_q, hold_d;
  logic              range_err_q, range_err_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_last_q, byte_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [COEFF_W-1:0] lane [LANES];
  logic [2:0]         lane_sel;
  logic [COEFF_W-1:0] c0, c1;
  byte_triple_t       packed_c;
  logic               oor_c;
  logic               last_k, last_word;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane[l] = rdata[l*COEFF_W +: COEFF_W];
  end

  // Pass q picks one adjacent lane pair; even lane is always the lower coefficient.
  assign lane_sel  = LANE_EVEN[q_q];
  assign c0        = lane[lane_sel];
  assign c1        = lane[{lane_sel[2:1], 1'b1}];
  assign last_k    = (k_q == K_W'(WORDS - 1));
  assign last_word = last_k && (q_q == 2'd3);

  byte_pack12 u_pack (
    .c0_i          (c0),
    .c1_i          (c1),
    .triple_c      (packed_c),
    .out_of_range_c(oor_c)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    q_d         = q_q;
    idx_d       = idx_q;
    off_d       = off_q;
    hold_d      = hold_q;
    range_err_d = range_err_q;
    byte_data_d = byte_data_q;
    byte_last_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          off_d       = ram_r_start_offset;
          k_d         = '0;
          q_d         = '0;
          range_err_d = 1'b0;
          state_d     = S_RD;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        hold_d      = packed_c;
        range_err_d = range_err_q | oor_c;
        idx_d       = '0;
        byte_data_d = packed_c.b0;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        byte_last_d = byte_last_q;
        if (byte_ready) begin
          if (idx_q == 2'd2) begin
            byte_last_d = 1'b0;
            if (last_word) begin
              state_d = S_FIN;
            end else begin
              state_d = S_RD;
              if (last_k) begin
                k_d = '0;
                q_d = q_q + 2'd1;
              end else begin
                k_d = k_q + K_W'(1);
              end
            end
          end else begin
            idx_d       = idx_q + 2'd1;
            byte_data_d = (idx_q == 2'd0) ? hold_q.b1 : hold_q.b2;
            byte_last_d = (idx_q == 2'd1) && last_word;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    ren_d        = (state_d == S_RD);
    raddr_d      = ren_d ? ADDR_W'(off_d + ADDR_W'(k_d)) : '0;
    byte_valid_d = (state_d == S_EMIT);
    busy_d       = (state_d == S_RD) || (state_d == S_CAP) || (state_d == S_EMIT);
    done_d       = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      q_q          <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      hold_q       <= '0;
      range_err_q  <= 1'b0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      q_q          <= q_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      hold_q       <= hold_d;
      range_err_q  <= range_err_d;
      ren_q        <= ren_d;
      raddr_q      <= raddr_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_last_q  <= byte_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ren        = ren_q;
  assign raddr      = raddr_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_last  = byte_last_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Scoreboard bench for poly_byte_encoder: expected bytes and read addresses are
// queued per run; a negedge monitor pops and compares on every handshake/read.
module tb_poly_byte_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ram_r_start_offset = 8'h00;
  logic        busy, done, ren;
  logic [7:0]  raddr;
  logic [95:0] rdata = '0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready = 1'b0;
  logic        byte_last;
  logic        range_err;

  always #5 clk = ~clk;

  poly_byte_encoder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .ram_r_start_offset(ram_r_start_offset),
    .busy              (busy),
    .done              (done),
    .ren               (ren),
    .raddr             (raddr),
    .rdata             (rdata),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .byte_last         (byte_last),
    .range_err         (range_err)
  );

  logic [95:0] mem [256];
  logic [11:0] a [256];

  // RAM model: one-cycle read latency.
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q [$];
  logic [7:0] addr_q [$];
  logic [7:0] got [384];
  logic       rerr_at [384];
  int  nbytes, ren_cnt, done_cnt, raddr_bad;
  int  cyc = 0;
  int  t_ren, t_fv, t_last, t_done, t_start;
  bit  rand_ready = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: address checks on reads, byte checks on handshakes, stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ren) begin
        ren_cnt++;
        if (t_ren < 0) t_ren = cyc;
        if (addr_q.size() == 0) check("ren_extra", 32'(ren_cnt), 32'd128);
        else check("raddr", 32'(raddr), 32'(addr_q.pop_front()));
      end else if (raddr != 8'h00) begin
        raddr_bad++;
      end
      if (prev_stall)
        check("stall_hold", {22'd0, byte_valid, byte_last, byte_data}, {22'd0, 1'b1, prev_last, prev_data});
      if (byte_valid) begin
        if (t_fv < 0) t_fv = cyc;
        if (byte_ready) begin
          if (exp_q.size() == 0) check("byte_extra", 32'(nbytes), 32'd384);
          else check($sformatf("byte%0d", nbytes), {23'd0, byte_last, byte_data}, {23'd0, exp_q.pop_front()});
          if (nbytes < 384) begin
            got[nbytes]     = byte_data;
            rerr_at[nbytes] = range_err;
          end
          nbytes++;
          if (byte_last) t_last = cyc;
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_data  = byte_data;
      prev_last  = byte_last;
      if (done) begin
        done_cnt++;
        t_done = cyc;
      end
    end
  end

  task automatic load(input logic [7:0] off, input bit bump);
    for (int n = 0; n < 256; n++) a[n] = 12'(n);
    if (bump) a[74] = 12'hFFF;
    for (int i = 0; i < 256; i++) mem[i] = {8{12'hA5A}} ^ 96'(i);
    for (int k = 0; k < 32; k++)
      mem[8'(off + 8'(k))] = {a[193+2*k], a[192+2*k], a[65+2*k], a[64+2*k],
                              a[129+2*k], a[128+2*k], a[2*k+1], a[2*k]};
  endtask

  task automatic arm(input logic [7:0] off);
    logic [11:0] c0, c1;
    exp_q.delete();
    addr_q.delete();
    for (int p = 0; p < 128; p++) begin
      c0 = a[2*p];
      c1 = a[2*p+1];
      exp_q.push_back({1'b0, c0[7:0]});
      exp_q.push_back({1'b0, c1[3:0], c0[11:8]});
      exp_q.push_back({p == 127, c1[11:4]});
    end
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < 32; k++) addr_q.push_back(8'(off + 8'(k)));
    nbytes = 0; ren_cnt = 0; done_cnt = 0; raddr_bad = 0;
    t_ren = -1; t_fv = -1; t_last = -1; t_done = -1;
    prev_stall = 1'b0;
  endtask

  task automatic run(input logic [7:0] off, input int abort_at, input int restart_at);
    int guard;
    bit pulsed;
    pulsed = 1'b0;
    ram_r_start_offset = off;
    @(posedge clk); #1;
    start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 4000 && !(abort_at >= 0 && nbytes >= abort_at)) begin
      if (restart_at >= 0 && !pulsed && nbytes >= restart_at) begin
        start = 1'b1;
        ram_r_start_offset = off ^ 8'h55;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
        ram_r_start_offset = off;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    ram_r_start_offset = off;
    check("run_timeout", 32'(guard >= 4000), 32'd0);
  endtask

  task automatic post(input bit timed, input logic rerr_exp);
    check("byte_count", 32'(nbytes), 32'd384);
    check("ren_count", 32'(ren_cnt), 32'd128);
    check("done_count", 32'(done_cnt), 32'd1);
    check("exp_left", 32'(exp_q.size()), 32'd0);
    check("addr_left", 32'(addr_q.size()), 32'd0);
    check("raddr_zero_when_idle", 32'(raddr_bad), 32'd0);
    check("done_after_last", 32'(t_done - t_last), 32'd1);
    // start is high in cycle t_start, accepted at its end; first byte two cycles later.
    check("first_valid_latency", 32'(t_fv - t_start), 32'd3);
    check("range_err", {31'd0, range_err}, {31'd0, rerr_exp});
    if (timed) begin
      check("ren_to_last_cycles", 32'(t_last - t_ren + 1), 32'd640);
      check("start_to_done", 32'(t_done - t_start), 32'd641);
    end
    repeat (3) @(posedge clk);
    #1;
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {10'd0, busy, done, ren, raddr, byte_valid, byte_data, byte_last, range_err}, 32'd0);
  endtask

  task automatic check_head(input string tag);
    logic [7:0] h [6];
    h = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h30, 8'h00};
    for (int i = 0; i < 6; i++) check($sformatf("%s_head%0d", tag, i), 32'(got[i]), 32'(h[i]));
  endtask

  initial begin
    logic [7:0] m [3];
    rst_n = 1'b0;
    load(8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // a(n)=n, offset 0, ready always high
    arm(8'h00);
    rand_ready = 1'b0;
    run(8'h00, -1, -1);
    post(1'b1, 1'b0);
    check_head("ramp");
    m = '{8'h40, 8'h10, 8'h04};
    for (int i = 0; i < 3; i++) check($sformatf("ramp_b%0d", 96 + i), 32'(got[96+i]), 32'(m[i]));

    // same data, random backpressure
    arm(8'h00);
    rand_ready = 1'b1;
    run(8'h00, -1, -1);
    rand_ready = 1'b0;
    post(1'b0, 1'b0);

    // wrapping base address
    load(8'hF0, 1'b0);
    arm(8'hF0);
    run(8'hF0, -1, -1);
    post(1'b1, 1'b0);
    check_head("wrap");

    // out-of-range coefficient a(74)=0xFFF in word 5 lane 4
    load(8'h00, 1'b1);
    arm(8'h00);
    run(8'h00, -1, -1);
    post(1'b1, 1'b1);
    check("oor_b111", 32'(got[111]), 32'h0000_00FF);
    check("oor_b112", 32'(got[112]), 32'h0000_00BF);
    check("rerr_before", {31'd0, rerr_at[110]}, 32'd0);
    check("rerr_after_cap", {31'd0, rerr_at[111]}, 32'd1);

    // reset at byte 200, then a clean run
    load(8'h00, 1'b0);
    arm(8'h00);
    run(8'h00, 200, -1);
    check("rerr_cleared_on_start", {31'd0, rerr_at[0]}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort_reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    arm(8'h00);
    run(8'h00, -1, -1);
    post(1'b1, 1'b0);

    // start pulsed again at byte 50 with a different offset: ignored
    arm(8'h00);
    run(8'h00, -1, 50);
    post(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
